// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath.
//
// A five-state FSM (FETCH, DECODE, EXEC, MEM, WB) drives the datapath muxes
// and enables. One variable-latency memory port, shared by instructions and
// data, is accessed through a req/ack handshake. The block also counts
// retired instructions.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   Op, Funct           instruction fields, stable from DECODE onward
//   Zero                ALU zero flag, valid in EXEC
//   mem_ack / mem_req   memory handshake; mem_req is held until mem_ack
//   IorD, MemWrite      memory address source and store strobe
//   IRWrite, MDRWrite   instruction / memory-data register loads
//   PCWrite, NPCOp      PC update enable and next-PC select
//   RegWrite, GPRSel,
//   WDSel               register-file write enable, destination, write data
//   ALUSrc, AregSel,
//   EXTOp, ALUOp        ALU operand selects, extender mode and operation
//   illegal             one-cycle pulse on an undecodable instruction
//   state, instret      registered FSM state and retired-instruction count
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        IorD,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MDRWrite,
  output logic        PCWrite,
  output logic [1:0]  NPCOp,
  output logic        RegWrite,
  output logic [1:0]  GPRSel,
  output logic [1:0]  WDSel,
  output logic        ALUSrc,
  output logic        AregSel,
  output logic        EXTOp,
  output logic [3:0]  ALUOp,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ClsIllegal, ClsRAlu, ClsIAlu, ClsLw, ClsSw, ClsBeq, ClsBne, ClsJ, ClsJal, ClsJr, ClsJalr
  } instr_e;

  localparam logic [3:0] AluNop  = 4'd0;
  localparam logic [3:0] AluAdd  = 4'd1;
  localparam logic [3:0] AluSub  = 4'd2;
  localparam logic [3:0] AluAnd  = 4'd3;
  localparam logic [3:0] AluOr   = 4'd4;
  localparam logic [3:0] AluSlt  = 4'd5;
  localparam logic [3:0] AluSltu = 4'd6;
  localparam logic [3:0] AluSll  = 4'd7;
  localparam logic [3:0] AluSrl  = 4'd8;
  localparam logic [3:0] AluNor  = 4'd9;
  localparam logic [3:0] AluLui  = 4'd10;
  localparam logic [3:0] AluXor  = 4'd11;

  state_e      state_q, state_d;
  logic [31:0] instret_q;

  instr_e     cls;
  logic [3:0] dec_alu_op;
  logic       dec_alu_src;
  logic       dec_areg_sel;
  logic       dec_ext_op;

  // Instruction decode: class plus the ALU controls used in EXEC.
  always_comb begin
    cls          = ClsIllegal;
    dec_alu_op   = AluNop;
    dec_alu_src  = 1'b0;
    dec_areg_sel = 1'b0;
    dec_ext_op   = 1'b0;
    case (Op)
      6'b000000: begin
        cls = ClsRAlu;
        case (Funct)
          6'b100000, 6'b100001: dec_alu_op = AluAdd;
          6'b100010, 6'b100011: dec_alu_op = AluSub;
          6'b100100:            dec_alu_op = AluAnd;
          6'b100101:            dec_alu_op = AluOr;
          6'b100110:            dec_alu_op = AluXor;
          6'b100111:            dec_alu_op = AluNor;
          6'b101010:            dec_alu_op = AluSlt;
          6'b101011:            dec_alu_op = AluSltu;
          6'b000000: begin dec_alu_op = AluSll; dec_areg_sel = 1'b1; end
          6'b000010: begin dec_alu_op = AluSrl; dec_areg_sel = 1'b1; end
          6'b000100:            dec_alu_op = AluSll;
          6'b000110:            dec_alu_op = AluSrl;
          6'b001000:            cls = ClsJr;
          6'b001001:            cls = ClsJalr;
          default:              cls = ClsIllegal;
        endcase
      end
      6'b001000: begin
        cls = ClsIAlu; dec_alu_op = AluAdd; dec_alu_src = 1'b1; dec_ext_op = 1'b1;
      end
      6'b001101: begin cls = ClsIAlu; dec_alu_op = AluOr;  dec_alu_src = 1'b1; end
      6'b001100: begin cls = ClsIAlu; dec_alu_op = AluAnd; dec_alu_src = 1'b1; end
      6'b001010: begin
        cls = ClsIAlu; dec_alu_op = AluSlt; dec_alu_src = 1'b1; dec_ext_op = 1'b1;
      end
      6'b001111: begin cls = ClsIAlu; dec_alu_op = AluLui; dec_alu_src = 1'b1; end
      6'b100011: begin
        cls = ClsLw; dec_alu_op = AluAdd; dec_alu_src = 1'b1; dec_ext_op = 1'b1;
      end
      6'b101011: begin
        cls = ClsSw; dec_alu_op = AluAdd; dec_alu_src = 1'b1; dec_ext_op = 1'b1;
      end
      6'b000100: begin cls = ClsBeq; dec_alu_op = AluSub; end
      6'b000101: begin cls = ClsBne; dec_alu_op = AluSub; end
      6'b000010: cls = ClsJ;
      6'b000011: cls = ClsJal;
      default:   cls = ClsIllegal;
    endcase
  end

  // Next-state and control outputs.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MDRWrite = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = 2'b00;
    RegWrite = 1'b0;
    GPRSel   = 2'b00;
    WDSel    = 2'b00;
    ALUSrc   = 1'b0;
    AregSel  = 1'b0;
    EXTOp    = 1'b0;
    ALUOp    = AluNop;
    illegal  = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          IRWrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (cls)
          ClsIllegal: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
          ClsJ: begin
            PCWrite = 1'b1;
            NPCOp   = 2'b10;
            state_d = StFetch;
          end
          ClsJal: begin
            PCWrite  = 1'b1;
            NPCOp    = 2'b10;
            RegWrite = 1'b1;
            GPRSel   = 2'b10;
            WDSel    = 2'b10;
            state_d  = StFetch;
          end
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        ALUOp   = dec_alu_op;
        ALUSrc  = dec_alu_src;
        AregSel = dec_areg_sel;
        EXTOp   = dec_ext_op;
        case (cls)
          ClsBeq: begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? 2'b01 : 2'b00;
            state_d = StFetch;
          end
          ClsBne: begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? 2'b00 : 2'b01;
            state_d = StFetch;
          end
          ClsJr: begin
            PCWrite = 1'b1;
            NPCOp   = 2'b11;
            state_d = StFetch;
          end
          ClsJalr: begin
            PCWrite  = 1'b1;
            NPCOp    = 2'b11;
            RegWrite = 1'b1;
            WDSel    = 2'b10;
            state_d  = StFetch;
          end
          ClsLw, ClsSw:     state_d = StMem;
          ClsRAlu, ClsIAlu: state_d = StWb;
          default:          state_d = StFetch;
        endcase
      end
      StMem: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = (cls == ClsSw);
        if (mem_ack) begin
          if (cls == ClsSw) begin
            PCWrite = 1'b1;
            state_d = StFetch;
          end else begin
            MDRWrite = 1'b1;
            state_d  = StWb;
          end
        end
      end
      StWb: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        state_d  = StFetch;
        if (cls == ClsLw) begin
          WDSel  = 2'b01;
          GPRSel = 2'b01;
        end else if (cls == ClsIAlu) begin
          GPRSel = 2'b01;
        end
      end
      default: state_d = StFetch;
    endcase

    if (rst) begin
      mem_req  = 1'b0;
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      MDRWrite = 1'b0;
      PCWrite  = 1'b0;
      NPCOp    = 2'b00;
      RegWrite = 1'b0;
      GPRSel   = 2'b00;
      WDSel    = 2'b00;
      ALUSrc   = 1'b0;
      AregSel  = 1'b0;
      EXTOp    = 1'b0;
      ALUOp    = AluNop;
      illegal  = 1'b0;
    end
  end

  // PCWrite fires exactly once per legal instruction, on its last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (PCWrite) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule
